mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one 64-bit memory port between the CPU instruction-fetch port and its data port.
//   Sits between the CPU IMEM_*/DMEM_* interfaces and a single unified memory.
//   Serialises requests: one outstanding transaction at a time.
//   Returns per-port acks that the pipeline uses as its stall source.
// PARAMETERS
//   ADDR_W      64  address width, byte address
//   DATA_W      64  memory word width; fixed at 64, since instruction lane select uses addr[2]
//   STARVE_MAX  4   consecutive data grants allowed while i_req waits, before the fetch is forced
// PORTS
//   clk      in   1       rising-edge clock, the block's only clock
//   rst_n    in   1       reset, asynchronous assert, active-low
//   i_req    in   1       fetch request; held high with i_addr stable until i_ack
//   i_addr   in   ADDR_W  fetch byte address, 4-byte aligned
//   i_rdata  out  32      fetched instruction; valid while i_ack=1, held until next i_ack
//   i_ack    out  1       1-cycle fetch completion pulse
//   d_req    in   1       data request (MemRead|MemWrite); held with d_* stable until d_ack
//   d_we     in   1       1=store, 0=load
//   d_addr   in   ADDR_W  data byte address, 8-byte aligned
//   d_wdata  in   DATA_W  store data
//   d_rdata  out  DATA_W  load data; valid while d_ack=1, held until next load d_ack
//   d_ack    out  1       1-cycle data completion pulse
//   m_valid  out  1       memory command valid
//   m_ready  in   1       memory accepts command this cycle (m_valid & m_ready)
//   m_we     out  1       command is a write
//   m_addr   out  ADDR_W  command address
//   m_wdata  out  DATA_W  write data
//   m_rvalid in   1       read data return, >=1 cycle after acceptance
//   m_rdata  in   DATA_W  read data
//   busy     out  1       state != IDLE
// BEHAVIOUR
//   Reset values
//     - rst_n=0 forces the FSM to IDLE immediately.
//     - All outputs go to 0, including i_rdata, d_rdata and starve_cnt.
//     - A reset mid-transaction abandons the transaction; no ack is issued for it.
//     - An m_rvalid arriving later in IDLE is ignored.
//   FSM states: IDLE -> CMD -> (RDWAIT) -> RESP -> IDLE
//     - IDLE: a grant loads m_addr, m_we and m_wdata from the winner, sets m_valid=1 and
//       records the owner (I or D) and lane = i_addr[2]; next state is CMD.
//     - CMD: m_valid=1 and m_addr/m_we/m_wdata are held stable until m_ready.
//       On m_ready: m_valid=0 at the next edge; a write goes to RESP, a read goes to RDWAIT.
//       m_rvalid in CMD is ignored.
//     - RDWAIT: on m_rvalid, capture the read data and go to RESP.
//       A fetch captures i_rdata = lane ? m_rdata[63:32] : m_rdata[31:0].
//       A load captures d_rdata = m_rdata.
//     - RESP: exactly one of i_ack/d_ack is 1 (the owner's), then IDLE.
//       A request still high during RESP is not regranted until the IDLE cycle after it.
//   Arbitration (IDLE only)
//     - d_req has priority; d_req is the older instruction in the pipeline.
//     - Exception: fetch wins when i_req=1 and starve_cnt==STARVE_MAX.
//     - starve_cnt: +1 on a D grant while i_req=1; cleared on an I grant, or on a grant
//       with i_req=0; saturates at STARVE_MAX.
//   Latency, zero-wait memory (m_ready=1, m_rvalid one cycle after accept)
//     - Request sampled in IDLE at cycle 0.
//     - Write ack at cycle 2; read ack at cycle 3.
//     - Back-to-back transactions: one per 4 cycles for reads.
//   Other rules
//     - At most one outstanding memory command.
//     - Addresses pass through unmodified; no width conversion beyond the fetch lane select.
//     - A request deasserted before its ack is a protocol violation; the transaction still completes.
// TESTING
//   1 Reset: hold rst_n=0 with i_req=1.
//     -> All outputs 0. Release rst_n; m_valid=1 with m_addr=i_addr one cycle later.
//   2 Fetch lane: i_addr=0x104, memory returns m_rdata=0xAAAA_BBBB_CCCC_DDDD.
//     -> i_rdata=0xAAAABBBB and i_ack pulses at cycle 3.
//     -> Repeat with i_addr=0x100 -> i_rdata=0xCCCCDDDD.
//   3 Simultaneous: i_req and d_req (store, 0x200, 0x1234) rise in the same cycle.
//     -> Store issued first, d_ack at cycle 2. Fetch then issued from the next IDLE.
//   4 Backpressure: m_ready=0 for 5 cycles after m_valid.
//     -> m_valid/m_addr/m_wdata stable throughout. Ack comes 1 (write) or 2+ (read) cycles after m_ready.
//   5 Starvation: d_req held high continuously with i_req=1, STARVE_MAX=4.
//     -> 4 data grants, then 1 fetch grant, then data resumes.
//   6 Reset mid-read: rst_n pulsed low in RDWAIT, with m_rvalid arriving after release.
//     -> No ack, d_rdata=0, busy=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Serialises CPU fetch and data requests onto one 64-bit memory
//             port, one outstanding transaction at a time.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CMD    = 2'd1;
    localparam logic [1:0] ST_RDWAIT = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]        state_q,   state_d;
    logic              m_valid_q, m_valid_d;
    logic              m_we_q,    m_we_d;
    logic [ADDR_W-1:0] m_addr_q,  m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              own_d_q,   own_d_d;    // 1 = data port owns the transaction
    logic              lane_q,    lane_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [SC_W-1:0]   starve_q,  starve_d;
    logic              fetch_win;

    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        own_d_d   = own_d_q;
        lane_d    = lane_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        starve_d  = starve_q;
        fetch_win = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    // Data is the older pipeline op, but a waiting fetch is forced through once starved.
                    fetch_win = i_req && (!d_req || (starve_q == STARVE_LIM));
                    state_d   = ST_CMD;
                    m_valid_d = 1'b1;
                    own_d_d   = !fetch_win;
                    lane_d    = i_addr[2];
                    m_we_d    = fetch_win ? 1'b0   : d_we;
                    m_addr_d  = fetch_win ? i_addr : d_addr;
                    m_wdata_d = fetch_win ? '0     : d_wdata;
                    if (!fetch_win && i_req)
                        starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
                    else
                        starve_d = '0;
                end
            end
            ST_CMD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = m_we_q ? ST_RESP : ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                if (m_rvalid) begin
                    if (own_d_q)
                        d_rdata_d = m_rdata;
                    else
                        i_rdata_d = lane_q ? m_rdata[63:32] : m_rdata[31:0];
                    state_d = ST_RESP;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            m_valid_q <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            own_d_q   <= 1'b0;
            lane_q    <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            own_d_q   <= own_d_d;
            lane_q    <= lane_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            starve_q  <= starve_d;
        end
    end

    assign i_ack   = (state_q == ST_RESP) && !own_d_q;
    assign d_ack   = (state_q == ST_RESP) &&  own_d_q;
    assign busy    = (state_q != ST_IDLE);
    assign m_valid = m_valid_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Brief    : Directed self-checking bench for mem_port_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [63:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [63:0] d_rdata;
    logic        d_ack;
    logic        m_valid;
    logic        m_ready;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic        m_rvalid;
    logic [63:0] m_rdata;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Zero-wait fetch: request seen in IDLE at cycle 0, ack expected at cycle 3.
    task automatic do_fetch(input logic [63:0] addr, input logic [63:0] mem,
                            input logic [31:0] exp, input string tag);
        i_req = 1'b1; i_addr = addr; m_ready = 1'b1; m_rvalid = 1'b0;
        step();
        chk({tag, "_c1_mvalid"}, m_valid, 1);
        chk({tag, "_c1_maddr"}, m_addr, addr);
        step();
        chk({tag, "_c2_iack"}, i_ack, 0);
        m_rvalid = 1'b1; m_rdata = mem;
        step();
        chk({tag, "_c3_iack"}, i_ack, 1);
        chk({tag, "_c3_irdata"}, i_rdata, exp);
        i_req = 1'b0; m_rvalid = 1'b0;
        step();
        chk({tag, "_c4_iack"}, i_ack, 0);
        chk({tag, "_c4_busy"}, busy, 0);
        chk({tag, "_c4_hold"}, i_rdata, exp);
    endtask

    initial begin
        logic [5:0] seq;
        int         n;
        logic [5:0] exp_seq;

        rst_n = 1'b0; i_req = 1'b1; i_addr = 64'h104;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;

        // Reset held with a fetch pending
        step(); step();
        chk("rst_mvalid", m_valid, 0);
        chk("rst_busy",   busy,    0);
        chk("rst_acks",   {i_ack, d_ack}, 0);
        chk("rst_maddr",  m_addr,  0);
        chk("rst_mwdata", m_wdata, 0);
        chk("rst_mwe",    m_we,    0);
        chk("rst_irdata", i_rdata, 0);
        chk("rst_drdata", d_rdata, 0);
        rst_n = 1'b1;
        step();
        chk("rel_mvalid", m_valid, 1);
        chk("rel_maddr",  m_addr,  64'h104);
        m_ready = 1'b1;
        step();
        chk("rel_accept_mvalid", m_valid, 0);
        m_rvalid = 1'b1; m_rdata = 64'h1111_2222_3333_4444;
        step();
        chk("rel_iack",   i_ack,   1);
        chk("rel_irdata", i_rdata, 32'h1111_2222);
        i_req = 1'b0; m_rvalid = 1'b0;
        step();

        // Fetch lane select
        do_fetch(64'h104, 64'hAAAA_BBBB_CCCC_DDDD, 32'hAAAA_BBBB, "lane_hi");
        do_fetch(64'h100, 64'hAAAA_BBBB_CCCC_DDDD, 32'hCCCC_DDDD, "lane_lo");

        // Simultaneous store and fetch: store first
        i_req = 1'b1; i_addr = 64'h108;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h200; d_wdata = 64'h1234;
        m_ready = 1'b1;
        step();
        chk("sim_c1_mwe",    m_we,    1);
        chk("sim_c1_maddr",  m_addr,  64'h200);
        chk("sim_c1_mwdata", m_wdata, 64'h1234);
        step();
        chk("sim_c2_dack", d_ack, 1);
        chk("sim_c2_iack", i_ack, 0);
        d_req = 1'b0;
        step();
        chk("sim_c3_idle", busy, 0);
        step();
        chk("sim_c4_mvalid", m_valid, 1);
        chk("sim_c4_maddr",  m_addr,  64'h108);
        chk("sim_c4_mwe",    m_we,    0);
        step();
        m_rvalid = 1'b1; m_rdata = 64'h5555_6666_7777_8888;
        step();
        chk("sim_iack",   i_ack,   1);
        chk("sim_irdata", i_rdata, 32'h7777_8888);
        i_req = 1'b0; m_rvalid = 1'b0;
        step();

        // Backpressure on a store
        m_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h300; d_wdata = 64'hDEAD_BEEF_0000_0001;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_mvalid", m_valid, 1);
            chk("bp_maddr",  m_addr,  64'h300);
            chk("bp_mwdata", m_wdata, 64'hDEAD_BEEF_0000_0001);
            chk("bp_dack",   d_ack,   0);
            step();
        end
        m_ready = 1'b1;
        step();
        chk("bp_w_dack",   d_ack,   1);
        chk("bp_w_mvalid", m_valid, 0);
        d_req = 1'b0; m_ready = 1'b0;
        step();

        // Backpressure on a load; early m_rvalid in CMD must be ignored
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h308;
        step();
        m_rvalid = 1'b1; m_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        chk("bpr_cmd_mvalid", m_valid, 1);
        m_ready = 1'b1; m_rvalid = 1'b0;
        step();
        chk("bpr_rdwait_dack", d_ack,   0);
        chk("bpr_ignored",     d_rdata, 0);
        m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 64'h0123_4567_89AB_CDEF;
        step();
        chk("bpr_dack",   d_ack,   1);
        chk("bpr_drdata", d_rdata, 64'h0123_4567_89AB_CDEF);
        d_req = 1'b0; m_rvalid = 1'b0;
        step();

        // Starvation: stores held continuously while a fetch waits
        i_req = 1'b1; i_addr = 64'h400;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h408; d_wdata = 64'h77;
        m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 64'h9999_0000_9999_0000;
        seq = '0; n = 0;
        exp_seq = 6'b101111;   // bit k = 1 when ack k came from the data port
        for (int c = 0; c < 60 && n < 6; c++) begin
            step();
            if (i_ack || d_ack) begin
                seq[n] = d_ack;
                n++;
            end
        end
        chk("starve_count", n, 6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("starve_ack%0d_is_data", k), seq[k], exp_seq[k]);
        i_req = 1'b0; d_req = 1'b0; m_rvalid = 1'b0;
        step(); step(); step();
        chk("starve_drain_busy", busy, 0);

        // Reset during RDWAIT, late m_rvalid after release
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h500; m_ready = 1'b1; m_rvalid = 1'b0;
        step();
        step();
        chk("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_async_busy",   busy,    0);
        chk("mid_async_mvalid", m_valid, 0);
        step();
        rst_n = 1'b1; d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        chk("mid_dack1", d_ack, 0);
        step();
        chk("mid_dack2",   d_ack,   0);
        chk("mid_drdata",  d_rdata, 0);
        chk("mid_irdata",  i_rdata, 0);
        chk("mid_busy",    busy,    0);
        chk("mid_mvalid",  m_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
